code_converter_pipe: RTL
========================

Name: code_converter_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit combinational code converter. It converts WIDTH-bit words between binary, Gray, packed multi-digit BCD and Excess-3, selected per transaction. It adds valid/ready flow control, a 2-stage pipeline, per-word invalid-digit flagging and a saturating error counter. It sits between a producer and consumer stream inside the datapath.

Parameters:
WIDTH, 8, data width in bits; must be a multiple of 4 (NDIG = WIDTH/4 digits); elaboration error otherwise
CNT_W, 8, width of error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  word to convert
in_mode  input  2  00 bin->Gray, 01 BCD->XS3, 10 Gray->bin, 11 XS3->BCD
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  converted word
out_mode  output  2  mode that produced out_data
out_err  output  1  word contained an invalid digit (BCD modes only)
err_cnt  output  CNT_W  saturating count of words delivered with out_err=1
cnt_clr  input  1  synchronous clear of err_cnt

Behaviour:
- One clock; reset asynchronous, active-low. During reset: in_ready=0, out_valid=0, out_data=0, out_mode=0, out_err=0, err_cnt=0; all stage valids cleared, in-flight words discarded (reset mid-stream drops data, no partial output after release).
- First cycle after reset release: in_ready=1.
- Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
- Stage 1 registers in_data/in_mode; stage 2 computes and registers out_data/out_mode/out_err. Latency: accepted at edge N -> out_valid high after edge N+2. Throughput 1 word/cycle with out_ready=1.
- Stall: stage 2 holds while out_valid&!out_ready; out_data/out_mode/out_err stable while held. Stage 1 advances when stage 2 empty or draining. in_ready = !s1_valid | !s2_valid | out_ready (combinational from out_ready permitted). Capacity 2 words; no loss, duplication or reordering.
- Mode 00: out = in ^ (in >> 1). out_err=0.
- Mode 10: out[WIDTH-1]=in[WIDTH-1]; out[i]=out[i+1]^in[i] downward. out_err=0.
- Mode 01: each nibble d -> (d+3) mod 16; err if any d>9.
- Mode 11: each nibble d -> (d-3) mod 16; err if any d<3 or d>12.
- Invalid digits still produce the modulo result; only out_err flags them.
- err_cnt increments by 1 on each output transfer with out_err=1; saturates at 2^CNT_W-1. cnt_clr has priority over a simultaneous increment (result 0).

Decomposition:
- Package code_conv_pkg: mode constants MODE_B2G=2'b00, MODE_BCD2XS3=2'b01, MODE_G2B=2'b10, MODE_XS32BCD=2'b11; XS3_OFFSET=4'd3; BCD_MAX=4'd9.
- Sub-module xs3_digit: one nibble plus direction in; converted nibble plus digit_err out. Instantiated NDIG times via generate in stage 2; Gray logic inline.

Test Plan:
- WIDTH=8, mode 00, in 8'hB5, out_ready=1 -> out_data 8'hEF, out_err 0, out_valid exactly 2 cycles after acceptance.
- Mode 10, in 8'hEF -> 8'hB5. Sweep all 256 values B2G then G2B; round trip returns the original.
- Mode 01, in 8'h59 -> 8'h8C, err 0. Then 8'h5A -> 8'h8D, err 1, err_cnt 1 after transfer.
- Mode 11, in 8'h8C -> 8'h59, err 0. Then 8'h21 -> 8'hFE, err 1, err_cnt 2.
- Push 4 back-to-back words with out_ready=0 for 3 cycles: in_ready drops after 2 accepted; out_data held stable; after release all 4 outputs in order, none duplicated.
- CNT_W=4: 20 invalid words -> err_cnt 15. cnt_clr with an error transfer in the same cycle -> 0. rst_n low with both stages full -> out_valid 0 immediately; no output after release.

Source files
------------

// File: rtl/code_conv_pkg.sv
// Shared definitions for the pipelined binary/Gray/BCD/Excess-3 converter.
// Mode encodings and digit-range constants used by the datapath.
package code_conv_pkg;

  localparam logic [1:0] MODE_B2G     = 2'b00;
  localparam logic [1:0] MODE_BCD2XS3 = 2'b01;
  localparam logic [1:0] MODE_G2B     = 2'b10;
  localparam logic [1:0] MODE_XS32BCD = 2'b11;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } stage_ctl_t;

  function automatic logic is_digit_mode(
    input logic [1:0] mode
  );
    return mode[0];
  endfunction

endpackage

// File: rtl/xs3_digit.sv
// Single-nibble BCD <-> Excess-3 converter with digit range flag.
// Out-of-range digits still yield the modulo-16 result.
module xs3_digit
  import code_conv_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       to_bcd,
  output logic [3:0] result,
  output logic       digit_err
);

  localparam logic [3:0] XS3_MAX = BCD_MAX + XS3_OFFSET;

  logic lo_bad;
  logic hi_bad;

  assign lo_bad = digit < XS3_OFFSET;
  assign hi_bad = digit > XS3_MAX;

  always_comb begin
    if (to_bcd) begin
      result    = digit - XS3_OFFSET;
      digit_err = lo_bad | hi_bad;
    end else begin
      result    = digit + XS3_OFFSET;
      digit_err = digit > BCD_MAX;
    end
  end

endmodule

// File: rtl/code_converter_pipe.sv
// Two-stage valid/ready code converter: binary/Gray and BCD/Excess-3
// with per-word invalid-digit flag and a saturating error counter.
module code_converter_pipe
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  localparam int NDIG = WIDTH / 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of 4");
  end

  logic             live;
  stage_ctl_t       s1;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;

  logic [WIDTH-1:0] gray_enc;
  logic [WIDTH-1:0] gray_dec;
  logic [WIDTH-1:0] xs3_word;
  logic [NDIG-1:0]  dig_err;
  logic [WIDTH-1:0] conv_data;
  logic             conv_err;
  logic             to_bcd;

  // stage 2 frees up when empty or when its word leaves this cycle
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = live && (!s1.valid || s2_adv);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s1_data <= '0;
    end else if (in_fire) begin
      s1.valid <= 1'b1;
      s1.mode  <= in_mode;
      s1_data  <= in_data;
    end else if (s2_adv) begin
      s1.valid <= 1'b0;
    end
  end

  assign gray_enc = s1_data ^ (s1_data >> 1);

  always_comb begin : g2b
    logic acc;
    acc      = 1'b0;
    gray_dec = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc         = acc ^ s1_data[i];
      gray_dec[i] = acc;
    end
  end

  assign to_bcd = s1.mode == MODE_XS32BCD;

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    xs3_digit u_dig (
      .digit     (s1_data[4*k +: 4]),
      .to_bcd    (to_bcd),
      .result    (xs3_word[4*k +: 4]),
      .digit_err (dig_err[k])
    );
  end

  always_comb begin
    conv_data = gray_enc;
    conv_err  = 1'b0;
    unique case (s1.mode)
      MODE_B2G: conv_data = gray_enc;
      MODE_G2B: conv_data = gray_dec;
      MODE_BCD2XS3,
      MODE_XS32BCD: begin
        conv_data = xs3_word;
        conv_err  = is_digit_mode(s1.mode) && (|dig_err);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_mode <= '0;
      out_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1.valid;
      if (s1.valid) begin
        out_data <= conv_data;
        out_mode <= s1.mode;
        out_err  <= conv_err;
      end
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_fire && out_err && err_cnt != CNT_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
